// File: rtl/systolic_feeder.sv
// systolic_feeder: operand sequencer for an N x N systolic MAC array.
// Takes one k-slice per handshake (column k of A, row k of B) and drives the
// array's west/north edges with a diagonal skew (lane i delayed i steps).
// Sequence per job: clear accumulators, feed K slices (frozen on stalls),
// drain with 2N-1 zero steps, then pulse done_o.
// Optional build macro: FEEDER_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of FEED cycles without valid_i for the current/last job.
module systolic_feeder #(
  parameter int N        = 4,
  parameter int NUM_BITS = 16,
  parameter int K_MAX    = 256,
  localparam int KW      = $clog2(K_MAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [KW-1:0]         k_len_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [N*NUM_BITS-1:0] a_i,
  input  logic [N*NUM_BITS-1:0] b_i,
  output logic [N*NUM_BITS-1:0] west_o,
  output logic [N*NUM_BITS-1:0] north_o,
  output logic                  pe_en_o,
  output logic                  clear_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [KW-1:0] K_MAX_W    = KW'(K_MAX);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(2 * N - 2);

  logic [2:0]    state;
  logic [KW-1:0] k_len_q;
  logic [KW-1:0] k_cnt;
  logic [KW-1:0] drain_cnt;
  logic          start_ok;
  logic          feeding;
  logic          accept;
  logic          last_slice;

  // Status decodes; only pe_en_o depends combinationally on an input.
  always_comb begin
    ready_o    = 1'b0;
    pe_en_o    = 1'b0;
    clear_o    = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    feeding    = 1'b0;
    accept     = 1'b0;
    start_ok   = (k_len_i != '0) && (k_len_i <= K_MAX_W);
    last_slice = (k_cnt == (k_len_q - KW'(1)));
    busy_o     = (state != S_IDLE);
    case (state)
      S_CLEAR: clear_o = 1'b1;
      S_FEED: begin
        ready_o = 1'b1;
        feeding = 1'b1;
        accept  = valid_i;
        pe_en_o = valid_i;
      end
      S_DRAIN: pe_en_o = 1'b1;
      S_DONE:  done_o  = 1'b1;
      default: ;
    endcase
  end

  // Job sequencing: state, latched K, slice and drain counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      k_len_q   <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && start_ok) begin
            k_len_q <= k_len_i;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          k_cnt <= '0;
          state <= S_FEED;
        end
        S_FEED: begin
          if (accept) begin
            k_cnt <= k_cnt + KW'(1);
            if (last_slice) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + KW'(1);
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int D = i + 1;

    logic [NUM_BITS-1:0]   w_in;
    logic [NUM_BITS-1:0]   n_in;
    logic [D*NUM_BITS-1:0] w_sr;
    logic [D*NUM_BITS-1:0] n_sr;

    // Drain phase injects zeros so the last slices flush through the array.
    assign w_in = feeding ? a_i[i*NUM_BITS +: NUM_BITS] : '0;
    assign n_in = feeding ? b_i[i*NUM_BITS +: NUM_BITS] : '0;

    // Lane skew line of depth i+1: newest stage in the LSBs, shifted on step.
    always_ff @(posedge clk_i) begin
      if (rst_i || clear_o) begin
        w_sr <= '0;
        n_sr <= '0;
      end else if (pe_en_o) begin
        w_sr <= (w_sr << NUM_BITS) | (D*NUM_BITS)'(w_in);
        n_sr <= (n_sr << NUM_BITS) | (D*NUM_BITS)'(n_in);
      end
    end

    assign west_o[i*NUM_BITS +: NUM_BITS]  = w_sr[D*NUM_BITS-1 -: NUM_BITS];
    assign north_o[i*NUM_BITS +: NUM_BITS] = n_sr[D*NUM_BITS-1 -: NUM_BITS];
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Saturating stall counter, restarted by each job's CLEAR cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state == S_CLEAR)) begin
      stall_cnt <= '0;
    end else if (feeding && !valid_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`endif

endmodule
